// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: register-driven pad outputs, synchronised (optionally ext-clock
// qualified) inputs, per-bit edge detect with sticky maskable interrupt.
module gpio_pad_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int ECLK_SYNC   = 2
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             reg_wr,
    input  logic             reg_rd,
    input  logic [2:0]       reg_addr,
    input  logic [WIDTH-1:0] reg_wdata,
    output logic [WIDTH-1:0] reg_rdata,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_oe,
    input  logic             ext_clk_pad_i,
    output logic             irq
);

    localparam logic [2:0] A_OUT   = 3'd0;
    localparam logic [2:0] A_OE    = 3'd1;
    localparam logic [2:0] A_INTE  = 3'd2;
    localparam logic [2:0] A_PTRIG = 3'd3;
    localparam logic [2:0] A_ECLK  = 3'd4;
    localparam logic [2:0] A_INTS  = 3'd5;
    localparam logic [2:0] A_IN    = 3'd6;

    logic [WIDTH-1:0] out_q,   out_d;
    logic [WIDTH-1:0] oe_q,    oe_d;
    logic [WIDTH-1:0] inte_q,  inte_d;
    logic [WIDTH-1:0] ptrig_q, ptrig_d;
    logic [WIDTH-1:0] eclk_q,  eclk_d;
    logic [WIDTH-1:0] ints_q,  ints_d;
    logic [WIDTH-1:0] in_q,    in_d;
    logic [WIDTH-1:0] prev_in_q, prev_in_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             irq_q,   irq_d;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [ECLK_SYNC-1:0]              eclk_sync_q, eclk_sync_d;
    logic                              eclk_hist_q, eclk_hist_d;

    logic [WIDTH-1:0] sync_in;
    logic             eclk_rise;
    logic [WIDTH-1:0] rise, fall, hit, w1c;

    assign sync_in   = sync_q[SYNC_STAGES-1];
    assign eclk_rise = eclk_sync_q[ECLK_SYNC-1] & ~eclk_hist_q;
    assign rise      = in_q & ~prev_in_q;
    assign fall      = ~in_q & prev_in_q;
    assign hit       = inte_q & ((ptrig_q & rise) | (~ptrig_q & fall));
    assign w1c       = (reg_wr && reg_addr == A_INTS) ? reg_wdata : '0;

    always_comb begin
        out_d       = out_q;
        oe_d        = oe_q;
        inte_d      = inte_q;
        ptrig_d     = ptrig_q;
        eclk_d      = eclk_q;
        sync_d      = {sync_q[SYNC_STAGES-2:0], pad_i};
        eclk_sync_d = {eclk_sync_q[ECLK_SYNC-2:0], ext_clk_pad_i};
        eclk_hist_d = eclk_sync_q[ECLK_SYNC-1];
        prev_in_d   = in_q;
        // Ext-clock qualified bits only follow the synchroniser on a qualified edge.
        in_d        = (sync_in & ~eclk_q) | ((eclk_rise ? sync_in : in_q) & eclk_q);
        // A hit in the same cycle as a W1C keeps the bit set.
        ints_d      = (ints_q & ~w1c) | hit;
        irq_d       = |ints_q;
        rdata_d     = rdata_q;

        if (reg_wr) begin
            case (reg_addr)
                A_OUT:   out_d   = reg_wdata;
                A_OE:    oe_d    = reg_wdata;
                A_INTE:  inte_d  = reg_wdata;
                A_PTRIG: ptrig_d = reg_wdata;
                A_ECLK:  eclk_d  = reg_wdata;
                default: ;
            endcase
        end

        if (reg_rd) begin
            case (reg_addr)
                A_OUT:   rdata_d = out_q;
                A_OE:    rdata_d = oe_q;
                A_INTE:  rdata_d = inte_q;
                A_PTRIG: rdata_d = ptrig_q;
                A_ECLK:  rdata_d = eclk_q;
                A_INTS:  rdata_d = ints_q;
                A_IN:    rdata_d = in_q;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            out_q       <= '0;
            oe_q        <= '0;
            inte_q      <= '0;
            ptrig_q     <= '0;
            eclk_q      <= '0;
            ints_q      <= '0;
            in_q        <= '0;
            prev_in_q   <= '0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
            sync_q      <= '0;
            eclk_sync_q <= '0;
            eclk_hist_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            oe_q        <= oe_d;
            inte_q      <= inte_d;
            ptrig_q     <= ptrig_d;
            eclk_q      <= eclk_d;
            ints_q      <= ints_d;
            in_q        <= in_d;
            prev_in_q   <= prev_in_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
            sync_q      <= sync_d;
            eclk_sync_q <= eclk_sync_d;
            eclk_hist_q <= eclk_hist_d;
        end
    end

    assign reg_rdata = rdata_q;
    assign pad_o     = out_q;
    assign pad_oe    = oe_q;
    assign irq       = irq_q;

endmodule
